// File: rtl/mcu_pkg.sv
// Shared constants for the multi-cycle MIPS control unit: state codes,
// opcodes, ALU operation codes, PC/RegDst mux codes and the control bundle.
package mcu_pkg;

  typedef enum logic [2:0] {
    ST_IF      = 3'b000,
    ST_ID      = 3'b001,
    ST_EXE_MEM = 3'b010,
    ST_MEM     = 3'b011,
    ST_WB_LW   = 3'b100,
    ST_EXE_BR  = 3'b101,
    ST_EXE_R   = 3'b110,
    ST_WB_R    = 3'b111
  } state_e;

  // Opcodes (IR[31:26])
  localparam logic [5:0] OP_ADD   = 6'b000000;
  localparam logic [5:0] OP_SUB   = 6'b000001;
  localparam logic [5:0] OP_ADDIU = 6'b000010;
  localparam logic [5:0] OP_AND   = 6'b010000;
  localparam logic [5:0] OP_ANDI  = 6'b010001;
  localparam logic [5:0] OP_OR    = 6'b010010;
  localparam logic [5:0] OP_ORI   = 6'b010011;
  localparam logic [5:0] OP_XOR   = 6'b010100;
  localparam logic [5:0] OP_XORI  = 6'b010101;
  localparam logic [5:0] OP_SLL   = 6'b011000;
  localparam logic [5:0] OP_SLT   = 6'b100111;
  localparam logic [5:0] OP_SW    = 6'b110000;
  localparam logic [5:0] OP_LW    = 6'b110001;
  localparam logic [5:0] OP_BEQ   = 6'b110100;
  localparam logic [5:0] OP_BNE   = 6'b110101;
  localparam logic [5:0] OP_BLTZ  = 6'b110110;
  localparam logic [5:0] OP_J     = 6'b111000;
  localparam logic [5:0] OP_JR    = 6'b111001;
  localparam logic [5:0] OP_JAL   = 6'b111010;
  localparam logic [5:0] OP_HALT  = 6'b111111;

  // ALU operations
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_SLL = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_AND = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;
  localparam logic [2:0] ALU_XOR = 3'b110;

  // PC source select
  localparam logic [1:0] PCSRC_NEXT   = 2'b00;
  localparam logic [1:0] PCSRC_BRANCH = 2'b01;
  localparam logic [1:0] PCSRC_RS     = 2'b10;
  localparam logic [1:0] PCSRC_JUMP   = 2'b11;

  // Write-register select, shared with the register file
  localparam logic [1:0] REGDST_RA = 2'b00;
  localparam logic [1:0] REGDST_RT = 2'b01;
  localparam logic [1:0] REGDST_RD = 2'b10;

  typedef struct packed {
    logic       pc_wre;
    logic       ir_wre;
    logic       reg_wre;
    logic [1:0] reg_dst;
    logic       wr_reg_d_src;
    logic       alu_src_a;
    logic       alu_src_b;
    logic       ext_sel;
    logic       db_data_src;
    logic       m_rd;
    logic       m_wr;
    logic [1:0] pc_src;
    logic [2:0] alu_op;
  } ctrl_t;

  // Three-register ALU instructions writing rd
  function automatic logic is_rtype(input logic [5:0] op);
    return op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLL, OP_SLT};
  endfunction

  // Immediate ALU instructions writing rt
  function automatic logic is_itype(input logic [5:0] op);
    return op inside {OP_ADDIU, OP_ANDI, OP_ORI, OP_XORI};
  endfunction

  function automatic logic is_branch(input logic [5:0] op);
    return op inside {OP_BEQ, OP_BNE, OP_BLTZ};
  endfunction

  function automatic logic is_jump(input logic [5:0] op);
    return op inside {OP_J, OP_JR, OP_JAL};
  endfunction

  function automatic logic is_legal(input logic [5:0] op);
    return is_rtype(op) || is_itype(op) || is_branch(op) || is_jump(op) ||
           (op inside {OP_LW, OP_SW, OP_HALT});
  endfunction

  // ALU operation used during execute of an ALU-class instruction
  function automatic logic [2:0] alu_op_of(input logic [5:0] op);
    logic [2:0] r;
    case (op)
      OP_SUB:           r = ALU_SUB;
      OP_SLL:           r = ALU_SLL;
      OP_OR,  OP_ORI:   r = ALU_OR;
      OP_AND, OP_ANDI:  r = ALU_AND;
      OP_SLT:           r = ALU_SLT;
      OP_XOR, OP_XORI:  r = ALU_XOR;
      default:          r = ALU_ADD;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mcu_ctrl_decode.sv
// Pure combinational decode of (state, opcode, flags) into datapath controls.
// Write enables are asserted in exactly one state per instruction.
module mcu_ctrl_decode
  import mcu_pkg::*;
(
  input  state_e     state_i,
  input  logic [5:0] opcode_i,
  input  logic       zero_i,
  input  logic       sign_i,
  output ctrl_t      ctrl_o
);

  logic taken_s;

  // Branch condition from the ALU flags of the rs-rt (or rs-0) subtraction
  always_comb begin
    taken_s = 1'b0;
    case (opcode_i)
      OP_BEQ:  taken_s = zero_i;
      OP_BNE:  taken_s = ~zero_i;
      OP_BLTZ: taken_s = sign_i;
      default: taken_s = 1'b0;
    endcase
  end

  // Per-state control decode
  always_comb begin
    ctrl_o = '0;
    case (state_i)
      ST_IF: begin
        ctrl_o.ir_wre = 1'b1;
      end
      ST_ID: begin
        if (opcode_i == OP_J) begin
          ctrl_o.pc_wre = 1'b1;
          ctrl_o.pc_src = PCSRC_JUMP;
        end else if (opcode_i == OP_JAL) begin
          ctrl_o.pc_wre       = 1'b1;
          ctrl_o.pc_src       = PCSRC_JUMP;
          ctrl_o.reg_wre      = 1'b1;
          ctrl_o.reg_dst      = REGDST_RA;
          ctrl_o.wr_reg_d_src = 1'b0;
        end else if (opcode_i == OP_JR) begin
          ctrl_o.pc_wre = 1'b1;
          ctrl_o.pc_src = PCSRC_RS;
        end else if (!is_legal(opcode_i)) begin
          // Unknown opcode retires as a NOP
          ctrl_o.pc_wre = 1'b1;
          ctrl_o.pc_src = PCSRC_NEXT;
        end else begin
          ctrl_o.pc_wre = 1'b0;
        end
      end
      ST_EXE_R, ST_WB_R: begin
        // Mux selects held through writeback so the write data stays stable
        ctrl_o.alu_src_a = (opcode_i == OP_SLL);
        ctrl_o.alu_src_b = is_itype(opcode_i);
        ctrl_o.ext_sel   = (opcode_i == OP_ADDIU);
        ctrl_o.alu_op    = alu_op_of(opcode_i);
        if (state_i == ST_WB_R) begin
          ctrl_o.reg_wre      = 1'b1;
          ctrl_o.reg_dst      = is_rtype(opcode_i) ? REGDST_RD : REGDST_RT;
          ctrl_o.wr_reg_d_src = 1'b1;
          ctrl_o.pc_wre       = 1'b1;
        end else begin
          ctrl_o.reg_wre = 1'b0;
        end
      end
      ST_EXE_BR: begin
        ctrl_o.alu_op = ALU_SUB;
        ctrl_o.pc_wre = 1'b1;
        ctrl_o.pc_src = taken_s ? PCSRC_BRANCH : PCSRC_NEXT;
      end
      ST_EXE_MEM, ST_MEM, ST_WB_LW: begin
        // Address = rs + sign-extended offset, held for the whole access
        ctrl_o.alu_src_b = 1'b1;
        ctrl_o.ext_sel   = 1'b1;
        ctrl_o.alu_op    = ALU_ADD;
        if (state_i == ST_MEM) begin
          if (opcode_i == OP_LW) begin
            ctrl_o.m_rd        = 1'b1;
            ctrl_o.db_data_src = 1'b1;
          end else begin
            ctrl_o.m_wr   = 1'b1;
            ctrl_o.pc_wre = 1'b1;
          end
        end else if (state_i == ST_WB_LW) begin
          ctrl_o.reg_wre      = 1'b1;
          ctrl_o.reg_dst      = REGDST_RT;
          ctrl_o.wr_reg_d_src = 1'b1;
          ctrl_o.db_data_src  = 1'b1;
          ctrl_o.pc_wre       = 1'b1;
        end else begin
          ctrl_o.m_rd = 1'b0;
        end
      end
      default: begin
        ctrl_o = '0;
      end
    endcase
  end

endmodule

// File: rtl/multi_cycle_control_unit.sv
// Multi-cycle MIPS control FSM: holds the state register, sequences each
// instruction IF/ID/EXE/MEM/WB and gates all controls off while in reset.
module multi_cycle_control_unit
  import mcu_pkg::*;
(
  input  logic       CLK,
  input  logic       Reset,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       sign,
  output logic       PCWre,
  output logic       IRWre,
  output logic       RegWre,
  output logic [1:0] RegDst,
  output logic       WrRegDSrc,
  output logic       ALUSrcA,
  output logic       ALUSrcB,
  output logic       ExtSel,
  output logic       DBDataSrc,
  output logic       mRD,
  output logic       mWR,
  output logic [1:0] PCSrc,
  output logic [2:0] ALUOp,
  output logic [2:0] state
);

  state_e state_q;
  state_e state_d;
  ctrl_t  ctrl_dec_s;
  ctrl_t  ctrl_s;

  // Next-state sequencing
  always_comb begin
    state_d = ST_IF;
    case (state_q)
      ST_IF: state_d = ST_ID;
      ST_ID: begin
        if (opcode == OP_HALT) begin
          state_d = ST_ID;
        end else if (is_jump(opcode) || !is_legal(opcode)) begin
          state_d = ST_IF;
        end else if (is_branch(opcode)) begin
          state_d = ST_EXE_BR;
        end else if (opcode == OP_LW || opcode == OP_SW) begin
          state_d = ST_EXE_MEM;
        end else begin
          state_d = ST_EXE_R;
        end
      end
      ST_EXE_R:   state_d = ST_WB_R;
      ST_WB_R:    state_d = ST_IF;
      ST_EXE_BR:  state_d = ST_IF;
      ST_EXE_MEM: state_d = ST_MEM;
      ST_MEM: begin
        if (opcode == OP_LW) begin
          state_d = ST_WB_LW;
        end else begin
          state_d = ST_IF;
        end
      end
      ST_WB_LW:   state_d = ST_IF;
      default:    state_d = ST_IF;
    endcase
  end

  // State register, returns to IF immediately on reset
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state_q <= ST_IF;
    end else begin
      state_q <= state_d;
    end
  end

  mcu_ctrl_decode u_decode (
    .state_i  (state_q),
    .opcode_i (opcode),
    .zero_i   (zero),
    .sign_i   (sign),
    .ctrl_o   (ctrl_dec_s)
  );

  // Every enable and mux select is forced low while reset is held
  always_comb begin
    if (Reset) begin
      ctrl_s = ctrl_dec_s;
    end else begin
      ctrl_s = '0;
    end
  end

  assign PCWre     = ctrl_s.pc_wre;
  assign IRWre     = ctrl_s.ir_wre;
  assign RegWre    = ctrl_s.reg_wre;
  assign RegDst    = ctrl_s.reg_dst;
  assign WrRegDSrc = ctrl_s.wr_reg_d_src;
  assign ALUSrcA   = ctrl_s.alu_src_a;
  assign ALUSrcB   = ctrl_s.alu_src_b;
  assign ExtSel    = ctrl_s.ext_sel;
  assign DBDataSrc = ctrl_s.db_data_src;
  assign mRD       = ctrl_s.m_rd;
  assign mWR       = ctrl_s.m_wr;
  assign PCSrc     = ctrl_s.pc_src;
  assign ALUOp     = ctrl_s.alu_op;
  assign state     = state_q;

endmodule

// File: tb/tb_multi_cycle_control_unit.sv
// Self-checking bench: each instruction's expected path and control pulses are
// derived from the instruction class rules, with randomized instruction mixes.
module tb_multi_cycle_control_unit;

  localparam logic [5:0] T_ADD = 6'b000000, T_SUB = 6'b000001, T_ADDIU = 6'b000010;
  localparam logic [5:0] T_AND = 6'b010000, T_ANDI = 6'b010001, T_OR = 6'b010010;
  localparam logic [5:0] T_ORI = 6'b010011, T_XOR = 6'b010100, T_XORI = 6'b010101;
  localparam logic [5:0] T_SLL = 6'b011000, T_SLT = 6'b100111, T_SW = 6'b110000;
  localparam logic [5:0] T_LW = 6'b110001, T_BEQ = 6'b110100, T_BNE = 6'b110101;
  localparam logic [5:0] T_BLTZ = 6'b110110, T_J = 6'b111000, T_JR = 6'b111001;
  localparam logic [5:0] T_JAL = 6'b111010, T_HALT = 6'b111111;

  logic       CLK = 1'b0;
  logic       Reset = 1'b0;
  logic [5:0] opcode = 6'b000000;
  logic       zero = 1'b0;
  logic       sign = 1'b0;
  logic       PCWre, IRWre, RegWre, WrRegDSrc, ALUSrcA, ALUSrcB, ExtSel, DBDataSrc, mRD, mWR;
  logic [1:0] RegDst, PCSrc;
  logic [2:0] ALUOp, state;

  int compared = 0;
  int mismatched = 0;

  logic [5:0] legal_ops [0:18] = '{T_ADD, T_SUB, T_ADDIU, T_AND, T_ANDI, T_OR, T_ORI,
                                   T_XOR, T_XORI, T_SLL, T_SLT, T_SW, T_LW, T_BEQ,
                                   T_BNE, T_BLTZ, T_J, T_JR, T_JAL};

  multi_cycle_control_unit dut (
    .CLK(CLK), .Reset(Reset), .opcode(opcode), .zero(zero), .sign(sign),
    .PCWre(PCWre), .IRWre(IRWre), .RegWre(RegWre), .RegDst(RegDst),
    .WrRegDSrc(WrRegDSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ExtSel(ExtSel),
    .DBDataSrc(DBDataSrc), .mRD(mRD), .mWR(mWR), .PCSrc(PCSrc), .ALUOp(ALUOp),
    .state(state)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic bit known_op(input logic [5:0] op);
    if (op == T_HALT) return 1'b1;
    for (int k = 0; k < 19; k++) if (legal_ops[k] == op) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit alu_r(input logic [5:0] op);
    return op inside {T_ADD, T_SUB, T_AND, T_OR, T_XOR, T_SLL, T_SLT};
  endfunction

  function automatic bit alu_i(input logic [5:0] op);
    return op inside {T_ADDIU, T_ANDI, T_ORI, T_XORI};
  endfunction

  function automatic bit br_op(input logic [5:0] op);
    return op inside {T_BEQ, T_BNE, T_BLTZ};
  endfunction

  // Arithmetic each instruction asks of the ALU
  function automatic logic [2:0] want_alu(input logic [5:0] op);
    case (op)
      T_SUB, T_BEQ, T_BNE, T_BLTZ: return 3'b001;
      T_SLL:                       return 3'b010;
      T_OR, T_ORI:                 return 3'b011;
      T_AND, T_ANDI:               return 3'b100;
      T_SLT:                       return 3'b101;
      T_XOR, T_XORI:               return 3'b110;
      default:                     return 3'b000;
    endcase
  endfunction

  // Runs one instruction from IF back to IF, checking every cycle
  task automatic run_instr(input logic [5:0] op, input logic z, input logic s, input string nm);
    logic [2:0] path [0:4];
    int         len;
    bit         last, writes, taken;
    logic [1:0] e_pcsrc, e_dst;
    logic       e_wsrc, e_db;
    path[0] = 3'b000; path[1] = 3'b001; path[2] = 3'b000; path[3] = 3'b000; path[4] = 3'b000;
    len = 2;
    if (op inside {T_J, T_JR, T_JAL} || !known_op(op)) begin
      len = 2;
    end else if (br_op(op)) begin
      path[2] = 3'b101; len = 3;
    end else if (op == T_LW) begin
      path[2] = 3'b010; path[3] = 3'b011; path[4] = 3'b100; len = 5;
    end else if (op == T_SW) begin
      path[2] = 3'b010; path[3] = 3'b011; len = 4;
    end else begin
      path[2] = 3'b110; path[3] = 3'b111; len = 4;
    end
    taken   = (op == T_BEQ && z) || (op == T_BNE && !z) || (op == T_BLTZ && s);
    e_pcsrc = (op inside {T_J, T_JAL}) ? 2'b11 : (op == T_JR) ? 2'b10 : taken ? 2'b01 : 2'b00;
    writes  = (op == T_JAL) || (op == T_LW) || alu_r(op) || alu_i(op);
    e_dst   = (op == T_JAL) ? 2'b00 : (op == T_LW || alu_i(op)) ? 2'b01 : 2'b10;
    e_wsrc  = (op != T_JAL);
    e_db    = (op == T_LW);
    opcode = op; zero = z; sign = s;
    #1;
    for (int i = 0; i < len; i++) begin
      last = (i == len - 1);
      compared++;
      if (state !== path[i]) begin
        mismatched++;
        $display("FAIL %s c%0d state: got %b want %b", nm, i, state, path[i]);
      end
      compared++;
      if ({IRWre, PCWre, RegWre, mRD, mWR} !==
          {i == 0, last, last && writes, op == T_LW && i == 3, op == T_SW && i == 3}) begin
        mismatched++;
        $display("FAIL %s c%0d enables{IR,PC,Reg,mRD,mWR}: got %b want %b", nm, i,
                 {IRWre, PCWre, RegWre, mRD, mWR},
                 {i == 0, last, last && writes, op == T_LW && i == 3, op == T_SW && i == 3});
      end
      if (last) begin
        compared++;
        if (PCSrc !== e_pcsrc) begin
          mismatched++;
          $display("FAIL %s c%0d PCSrc: got %b want %b", nm, i, PCSrc, e_pcsrc);
        end
      end
      if (last && writes) begin
        compared++;
        if ({RegDst, WrRegDSrc, DBDataSrc} !== {e_dst, e_wsrc, e_db}) begin
          mismatched++;
          $display("FAIL %s c%0d {RegDst,WrRegDSrc,DBDataSrc}: got %b want %b", nm, i,
                   {RegDst, WrRegDSrc, DBDataSrc}, {e_dst, e_wsrc, e_db});
        end
      end
      if (i == 2) begin
        compared++;
        if ({ALUOp, ALUSrcA, ALUSrcB} !==
            {want_alu(op), op == T_SLL, alu_i(op) || op == T_LW || op == T_SW}) begin
          mismatched++;
          $display("FAIL %s exe {ALUOp,SrcA,SrcB}: got %b want %b", nm,
                   {ALUOp, ALUSrcA, ALUSrcB},
                   {want_alu(op), op == T_SLL, alu_i(op) || op == T_LW || op == T_SW});
        end
        if (alu_i(op) || op == T_LW || op == T_SW) begin
          compared++;
          if (ExtSel !== (op != T_ANDI && op != T_ORI && op != T_XORI)) begin
            mismatched++;
            $display("FAIL %s exe ExtSel: got %b want %b", nm, ExtSel,
                     (op != T_ANDI && op != T_ORI && op != T_XORI));
          end
        end
      end
      @(negedge CLK); #1;
    end
    compared++;
    if (state !== 3'b000) begin
      mismatched++;
      $display("FAIL %s return-to-IF: got %b want 000", nm, state);
    end
  endtask

  task automatic test_reset();
    Reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK); #1;
      compared++;
      if ({state, PCWre, IRWre, RegWre, mRD, mWR, RegDst, WrRegDSrc, ALUSrcA, ALUSrcB,
           ExtSel, DBDataSrc, PCSrc, ALUOp} !== 21'd0) begin
        mismatched++;
        $display("FAIL reset_low c%0d: state %b IRWre %b PCWre %b muxes %b", i, state, IRWre,
                 PCWre, {RegDst, WrRegDSrc, ALUSrcA, ALUSrcB, ExtSel, DBDataSrc, PCSrc, ALUOp});
      end
    end
    Reset = 1'b1;
    #1;
    compared++;
    if ({state, IRWre, PCWre, RegWre, mRD, mWR} !== 8'b000_1_0000) begin
      mismatched++;
      $display("FAIL reset_release: got %b want 00010000",
               {state, IRWre, PCWre, RegWre, mRD, mWR});
    end
  endtask

  task automatic test_rtype();
    run_instr(T_ADD, 1'b0, 1'b0, "add");
    run_instr(T_SLL, 1'b1, 1'b0, "sll");
    run_instr(T_ORI, 1'b0, 1'b1, "ori");
  endtask

  task automatic test_lw_sw();
    run_instr(T_LW, 1'b0, 1'b0, "lw");
    run_instr(T_SW, 1'b0, 1'b0, "sw");
  endtask

  task automatic test_branch();
    run_instr(T_BEQ, 1'b1, 1'b0, "beq_z1");
    run_instr(T_BEQ, 1'b0, 1'b0, "beq_z0");
    run_instr(T_BNE, 1'b0, 1'b1, "bne_z0");
    run_instr(T_BLTZ, 1'b0, 1'b1, "bltz_s1");
    run_instr(T_BLTZ, 1'b1, 1'b0, "bltz_s0");
  endtask

  task automatic test_jumps();
    run_instr(T_JAL, 1'b0, 1'b0, "jal");
    run_instr(T_J, 1'b1, 1'b1, "j");
    run_instr(T_JR, 1'b0, 1'b0, "jr");
    run_instr(6'b001111, 1'b0, 1'b0, "illegal");
  endtask

  task automatic test_halt();
    opcode = T_HALT;
    @(negedge CLK); #1;
    for (int i = 0; i < 20; i++) begin
      compared++;
      if ({state, PCWre, IRWre, RegWre, mRD, mWR} !== 8'b001_00000) begin
        mismatched++;
        $display("FAIL halt c%0d: got %b want 00100000", i,
                 {state, PCWre, IRWre, RegWre, mRD, mWR});
      end
      @(negedge CLK); #1;
    end
    Reset = 1'b0;
    #1;
    compared++;
    if (state !== 3'b000) begin
      mismatched++;
      $display("FAIL halt_reset state: got %b want 000", state);
    end
    @(negedge CLK);
    Reset = 1'b1;
    #1;
  endtask

  task automatic test_reset_mid_mem();
    opcode = T_SW;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK); #1;
    end
    compared++;
    if ({state, mWR} !== 4'b011_1) begin
      mismatched++;
      $display("FAIL sw_mem_before_reset {state,mWR}: got %b want 0111", {state, mWR});
    end
    Reset = 1'b0;
    #1;
    compared++;
    if ({state, mWR, PCWre, IRWre, RegWre, mRD} !== 8'b000_00000) begin
      mismatched++;
      $display("FAIL reset_mid_mem: got %b want 00000000",
               {state, mWR, PCWre, IRWre, RegWre, mRD});
    end
    @(negedge CLK);
    Reset = 1'b1;
    #1;
    run_instr(T_XOR, 1'b0, 1'b0, "xor_after_reset");
  endtask

  task automatic test_random();
    logic [5:0] op;
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(7) == 0) begin
        op = 6'b001111;
        for (int t = 0; t < 64; t++) begin
          op = 6'($urandom_range(63));
          if (!known_op(op)) break;
        end
        if (known_op(op)) op = 6'b001111;
      end else begin
        op = legal_ops[$urandom_range(18)];
      end
      run_instr(op, 1'($urandom_range(1)), 1'($urandom_range(1)), "random");
    end
  endtask

  task automatic test_back_to_back();
    run_instr(T_LW, 1'b1, 1'b1, "b2b_lw");
    run_instr(T_SUB, 1'b1, 1'b1, "b2b_sub");
    run_instr(T_JAL, 1'b1, 1'b1, "b2b_jal");
    run_instr(T_SW, 1'b1, 1'b1, "b2b_sw");
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_lw_sw();
    test_branch();
    test_jumps();
    test_back_to_back();
    test_random();
    test_reset_mid_mem();
    test_halt();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
